// File: rtl/daw_step_sequencer.sv
// daw_step_sequencer
//   Pattern and transport engine for the DAW screen, clocked by vga_clk.
//   Debounces KEY[3:1], keeps a 4-track x 16-step on/off grid edited with KEY/SW,
//   and runs a BPM-driven playhead that emits per-step note_on strobes.
//
// Ports
//   vga_clk      in   clock for the whole block
//   rst_n        in   synchronous active-low reset
//   btn_n[2:0]   in   raw KEY3..KEY1, active-low, asynchronous, bouncy
//   sw[9:0]      in   [1:0] track select, [9] tempo mode (1 = KEY1/KEY2 change bpm)
//   grid[63:0]   out  pattern, bit t*16+s = track t, step s
//   cursor_track out  registered sw[1:0]
//   cursor_step  out  edit column
//   playhead     out  current playback column
//   playing      out  1 while in PLAY (this is the FSM state bit)
//   step_pulse   out  1-cycle strobe when the playhead lands on a column
//   note_on[3:0] out  grid column at the new playhead, valid with step_pulse
//   bpm[7:0]     out  current tempo, BPM_MIN..BPM_MAX
//
// Strobe semantics: step_pulse is a single-cycle qualifier; note_on is only
// meaningful in a cycle where step_pulse is 1 and is zero otherwise. There is
// no back-pressure.
module daw_step_sequencer #(
  parameter int CLK_HZ       = 25_000_000,
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int BPM_RESET    = 120,
  parameter int BPM_MIN      = 60,
  parameter int BPM_MAX      = 240,
  parameter int BPM_STEP     = 4
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [2:0]  btn_n,
  input  logic [9:0]  sw,
  output logic [63:0] grid,
  output logic [1:0]  cursor_track,
  output logic [3:0]  cursor_step,
  output logic [3:0]  playhead,
  output logic        playing,
  output logic        step_pulse,
  output logic [3:0]  note_on,
  output logic [7:0]  bpm
);

  // One 16th note at bpm beats/min is CLK_HZ*60/(4*bpm) cycles; accumulating
  // bpm per cycle against CLK_HZ*15 gives that period without a divider.
  localparam int TH    = CLK_HZ * 15;
  localparam int ACC_W = $clog2(TH + BPM_MAX);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic {ST_STOP = 1'b0, ST_PLAY = 1'b1} state_e;

  // Button path (all active-low levels)
  logic [2:0]       sync1_q, sync2_q, lvl_q, press_q;
  logic [2:0]       sync1_d, sync2_d, lvl_d, press_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // Pattern / transport
  state_e           state_q, state_d;
  logic [63:0]      grid_q, grid_d;
  logic [1:0]       track_q, track_d;
  logic [3:0]       cstep_q, cstep_d;
  logic [3:0]       phead_q, phead_d;
  logic             pulse_q, pulse_d;
  logic [3:0]       note_q, note_d;
  logic [7:0]       bpm_q, bpm_d, bpm_t;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

  logic key1, key2, key3;
  logic unused_sw;

  assign unused_sw = ^sw[8:2];
  assign key1 = press_q[0];
  assign key2 = press_q[1];
  assign key3 = press_q[2];

  function automatic logic [3:0] column(input logic [63:0] g, input logic [3:0] s);
    column = {g[{2'd3, s}], g[{2'd2, s}], g[{2'd1, s}], g[{2'd0, s}]};
  endfunction

  // Debounce: the counter only runs while the synced level differs from the
  // accepted level, so any bounce back to the accepted level reloads it.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    press_d = 3'b000;
    cnt_d   = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt_d[i]   = '0;
        lvl_d[i]   = sync2_q[i];
        press_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edits, tempo and transport FSM
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    track_d = sw[1:0];
    cstep_d = cstep_q;
    phead_d = phead_q;
    pulse_d = 1'b0;
    note_d  = 4'd0;
    bpm_t   = bpm_q;
    bpm_d   = bpm_q;
    acc_d   = acc_q;
    acc_sum = acc_q + ACC_W'(bpm_q);

    if (!sw[9]) begin
      if (key1) cstep_d = cstep_q + 4'd1;
      if (key2) grid_d[{track_q, cstep_q}] = ~grid_q[{track_q, cstep_q}];
    end else begin
      // Both keys in one cycle: decrement then increment, each saturating.
      if (key1) begin
        if (bpm_q <= 8'(BPM_MIN + BPM_STEP)) bpm_t = 8'(BPM_MIN);
        else                                 bpm_t = bpm_q - 8'(BPM_STEP);
      end
      bpm_d = bpm_t;
      if (key2) begin
        if (bpm_t >= 8'(BPM_MAX - BPM_STEP)) bpm_d = 8'(BPM_MAX);
        else                                 bpm_d = bpm_t + 8'(BPM_STEP);
      end
    end

    // note_on always reads grid_q, so a toggle in the same cycle as a step
    // is heard on the next pass.
    case (state_q)
      ST_STOP: begin
        if (key3) begin
          state_d = ST_PLAY;
          phead_d = 4'd0;
          acc_d   = '0;
          pulse_d = 1'b1;
          note_d  = column(grid_q, 4'd0);
        end
      end
      ST_PLAY: begin
        if (key3) begin
          // Stop wins over a step landing in the same cycle.
          state_d = ST_STOP;
          acc_d   = '0;
        end else if (acc_sum >= ACC_W'(TH)) begin
          acc_d   = acc_sum - ACC_W'(TH);
          phead_d = phead_q + 4'd1;
          pulse_d = 1'b1;
          note_d  = column(grid_q, phead_q + 4'd1);
        end else begin
          acc_d = acc_sum;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      lvl_q   <= 3'b111;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q <= ST_STOP;
      grid_q  <= 64'd0;
      track_q <= 2'd0;
      cstep_q <= 4'd0;
      phead_q <= 4'd0;
      pulse_q <= 1'b0;
      note_q  <= 4'd0;
      bpm_q   <= 8'(BPM_RESET);
      acc_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      grid_q  <= grid_d;
      track_q <= track_d;
      cstep_q <= cstep_d;
      phead_q <= phead_d;
      pulse_q <= pulse_d;
      note_q  <= note_d;
      bpm_q   <= bpm_d;
      acc_q   <= acc_d;
    end
  end

  assign grid         = grid_q;
  assign cursor_track = track_q;
  assign cursor_step  = cstep_q;
  assign playhead     = phead_q;
  assign playing      = (state_q == ST_PLAY);
  assign step_pulse   = pulse_q;
  assign note_on      = note_q;
  assign bpm          = bpm_q;

endmodule

// File: tb/tb_daw_step_sequencer.sv
// Bench for daw_step_sequencer with CLK_HZ=1600 (TH=24000) and DEBOUNCE_CYC=4.
module tb_daw_step_sequencer;
  localparam int W = 8;

  logic        vga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  btn_n = 3'b111;
  logic [9:0]  sw = 10'd0;
  logic [63:0] grid;
  logic [1:0]  cursor_track;
  logic [3:0]  cursor_step, playhead, note_on;
  logic        playing, step_pulse;
  logic [7:0]  bpm;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           pulse_cyc[$];
  logic [W-1:0] pulse_val[$];

  daw_step_sequencer #(.CLK_HZ(1600), .DEBOUNCE_CYC(4)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .btn_n(btn_n), .sw(sw),
    .grid(grid), .cursor_track(cursor_track), .cursor_step(cursor_step),
    .playhead(playhead), .playing(playing), .step_pulse(step_pulse),
    .note_on(note_on), .bpm(bpm)
  );

  // Clock / monitor
  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) begin
    cyc = cyc + 1;
    if (step_pulse === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back({playhead, note_on});
    end
  end

  // Driver tasks (always entered and left just after a negedge)
  task automatic press(input int k, input int low_cyc);
    btn_n[k] = 1'b0;
    repeat (low_cyc) @(negedge vga_clk);
    btn_n[k] = 1'b1;
    repeat (10) @(negedge vga_clk);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int t = 0;
    while (pulse_cyc.size() < n && t < budget) begin
      @(negedge vga_clk);
      t++;
    end
    n_checks++;
    if (pulse_cyc.size() < n)
      $display("FAIL %s_timeout: got %0d pulses, expected %0d", name, pulse_cyc.size(), n);
    else n_pass++;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    n_checks++; if (grid !== 64'd0) $display("FAIL reset_grid: got %h expected 0", grid); else n_pass++;
    n_checks++; if (bpm !== 8'd120) $display("FAIL reset_bpm: got %0d expected 120", bpm); else n_pass++;
    n_checks++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b expected 0", playing); else n_pass++;
    n_checks++; if (playhead !== 4'd0) $display("FAIL reset_playhead: got %0d expected 0", playhead); else n_pass++;
    n_checks++; if (note_on !== 4'd0) $display("FAIL reset_note_on: got %b expected 0", note_on); else n_pass++;
    n_checks++; if (step_pulse !== 1'b0) $display("FAIL reset_step_pulse: got %b expected 0", step_pulse); else n_pass++;
    n_checks++; if (cursor_step !== 4'd0) $display("FAIL reset_cursor_step: got %0d expected 0", cursor_step); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic test_debounce();
    press(0, 2);
    n_checks++; if (cursor_step !== 4'd0) $display("FAIL glitch2: got %0d expected 0", cursor_step); else n_pass++;
    press(0, 3);
    n_checks++; if (cursor_step !== 4'd0) $display("FAIL glitch3: got %0d expected 0", cursor_step); else n_pass++;
    press(0, 4);
    n_checks++; if (cursor_step !== 4'd1) $display("FAIL min_press: got %0d expected 1", cursor_step); else n_pass++;
    press(0, 12);
    n_checks++; if (cursor_step !== 4'd2) $display("FAIL long_press_once: got %0d expected 2", cursor_step); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      press(0, 5 + $urandom_range(0, 6));
      n_checks++;
      if (cursor_step !== 4'((3 + i) % 16))
        $display("FAIL step_wrap: got %0d expected %0d", cursor_step, (3 + i) % 16);
      else n_pass++;
    end
  endtask

  task automatic test_toggle();
    sw = 10'd2;
    repeat (5) press(0, 8);
    n_checks++; if (cursor_step !== 4'd5) $display("FAIL toggle_cursor: got %0d expected 5", cursor_step); else n_pass++;
    n_checks++; if (cursor_track !== 2'd2) $display("FAIL toggle_track: got %0d expected 2", cursor_track); else n_pass++;
    press(1, 8);
    n_checks++; if (grid !== (64'd1 << 37)) $display("FAIL toggle_on: got %h expected %h", grid, 64'd1 << 37); else n_pass++;
    press(1, 8);
    n_checks++; if (grid !== 64'd0) $display("FAIL toggle_off: got %h expected 0", grid); else n_pass++;
  endtask

  task automatic test_play();
    int base;
    logic [W-1:0] e;
    logic [3:0] ph;
    sw = 10'd0;
    repeat (11) press(0, 8);
    press(1, 8);
    sw = 10'd1;
    repeat (3) press(0, 8);
    press(1, 8);
    n_checks++; if (grid !== 64'h80001) $display("FAIL play_grid: got %h expected 80001", grid); else n_pass++;
    base = pulse_cyc.size();
    for (int k = 0; k < 18; k++) begin
      ph = 4'(k % 16);
      exp_q.push_back({ph, (ph == 4'd0) ? 4'b0001 : (ph == 4'd3) ? 4'b0010 : 4'b0000});
    end
    press(2, 8);
    n_checks++; if (playing !== 1'b1) $display("FAIL play_state: got %b expected 1", playing); else n_pass++;
    wait_pulses(base + 18, 18 * 200 + 100, "play");
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (base + i >= pulse_val.size() || pulse_val[base + i] !== e)
        $display("FAIL play_step%0d: got %h expected %h", i,
                 (base + i < pulse_val.size()) ? pulse_val[base + i] : 8'hxx, e);
      else n_pass++;
      if (i > 0 && base + i < pulse_cyc.size()) begin
        n_checks++;
        if (pulse_cyc[base + i] - pulse_cyc[base + i - 1] != 200)
          $display("FAIL play_period%0d: got %0d expected 200", i, pulse_cyc[base + i] - pulse_cyc[base + i - 1]);
        else n_pass++;
      end
    end
    press(2, 8);
    n_checks++; if (playing !== 1'b0) $display("FAIL stop_state: got %b expected 0", playing); else n_pass++;
    base = pulse_cyc.size();
    repeat (300) @(negedge vga_clk);
    n_checks++; if (pulse_cyc.size() != base) $display("FAIL stop_no_pulse: got %0d expected %0d", pulse_cyc.size(), base); else n_pass++;
    n_checks++; if (playhead !== 4'd1) $display("FAIL stop_hold: got %0d expected 1", playhead); else n_pass++;
  endtask

  task automatic measure_period(input int period, input string name);
    int base = pulse_cyc.size();
    press(2, 8);
    wait_pulses(base + 3, 3 * period + 100, name);
    if (pulse_cyc.size() >= base + 3) begin
      n_checks++;
      if (pulse_cyc[base + 1] - pulse_cyc[base] != period)
        $display("FAIL %s_p1: got %0d expected %0d", name, pulse_cyc[base + 1] - pulse_cyc[base], period);
      else n_pass++;
      n_checks++;
      if (pulse_cyc[base + 2] - pulse_cyc[base + 1] != period)
        $display("FAIL %s_p2: got %0d expected %0d", name, pulse_cyc[base + 2] - pulse_cyc[base + 1], period);
      else n_pass++;
    end
    press(2, 8);
  endtask

  task automatic test_tempo();
    int e;
    sw = 10'h200;
    for (int i = 0; i < 40; i++) begin
      press(1, 8);
      e = (120 + 4 * (i + 1) > 240) ? 240 : 120 + 4 * (i + 1);
      n_checks++; if (bpm !== 8'(e)) $display("FAIL bpm_up%0d: got %0d expected %0d", i, bpm, e); else n_pass++;
    end
    measure_period(100, "fast");
    for (int i = 0; i < 50; i++) begin
      press(0, 8);
      e = (240 - 4 * (i + 1) < 60) ? 60 : 240 - 4 * (i + 1);
      n_checks++; if (bpm !== 8'(e)) $display("FAIL bpm_dn%0d: got %0d expected %0d", i, bpm, e); else n_pass++;
    end
    measure_period(400, "slow");
  endtask

  task automatic test_reset_midplay();
    int t = 0;
    int base;
    press(2, 8);
    while (t < 4000 && !(pulse_val.size() > 0 && pulse_val[pulse_val.size() - 1][7:4] == 4'd7)) begin
      @(negedge vga_clk);
      t++;
    end
    n_checks++; if (t >= 4000) $display("FAIL midplay_reach7: got timeout expected playhead 7"); else n_pass++;
    repeat (5) @(negedge vga_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
    base = pulse_cyc.size();
    n_checks++; if (playing !== 1'b0) $display("FAIL midrst_playing: got %b expected 0", playing); else n_pass++;
    n_checks++; if (playhead !== 4'd0) $display("FAIL midrst_playhead: got %0d expected 0", playhead); else n_pass++;
    n_checks++; if (bpm !== 8'd120) $display("FAIL midrst_bpm: got %0d expected 120", bpm); else n_pass++;
    n_checks++; if (grid !== 64'd0) $display("FAIL midrst_grid: got %h expected 0", grid); else n_pass++;
    repeat (1000) @(negedge vga_clk);
    n_checks++; if (pulse_cyc.size() != base) $display("FAIL midrst_no_pulse: got %0d expected %0d", pulse_cyc.size(), base); else n_pass++;
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_debounce();
    test_toggle();
    test_play();
    test_tempo();
    test_reset_midplay();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
